feb_dly_prog: RTL and testbench
===============================

FEB_DLY_PROG -- requirements
Module: feb_dly_prog

Interface
REQ-001 Parameter NCHIP, 7, number of cascaded FEB clock-delay chips in the serial chain.
REQ-002 Parameter DBITS, 5, delay-code bits per chip.
REQ-003 Parameter CLKDIV, 2, CLKCMS cycles per FEBDLYCLK half-period (legal range 1..15).
REQ-004 CLKCMS  input  1  sole clock, 40 MHz CMS clock; all logic on its rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 START  input  1  one-cycle request to program the chain.
REQ-007 DLY_VEC  input  NCHIP*DBITS  delay codes; chip k occupies bits [k*DBITS+DBITS-1 : k*DBITS].
REQ-008 FEBDLYAE  output  1  chain address/enable, high during shifting.
REQ-009 FEBDLYCLK  output  1  serial shift clock to the chips.
REQ-010 FEBDLYIN  output  1  serial data to the chips.
REQ-011 FEBLOADDLY  output  1  latch strobe that transfers the shifted codes into the delay taps.
REQ-012 BUSY  output  1  high while a programming sequence is active.
REQ-013 DONE  output  1  one-cycle pulse when a sequence completes.

Function
REQ-014 States: IDLE, SHIFT, LOAD, FINISH. The block SHALL be in IDLE after reset.
REQ-015 In IDLE, START=1 SHALL capture DLY_VEC into an internal NCHIP*DBITS shift register, clear the bit and divider counters, and enter SHIFT on the next edge.
REQ-016 START SHALL be ignored in all states other than IDLE. DLY_VEC changes after capture SHALL have no effect on the sequence in progress.
REQ-017 SHIFT: FEBDLYAE=1. Bits go out MSB first (bit NCHIP*DBITS-1 first, bit 0 last). Each bit holds FEBDLYIN stable for 2*CLKDIV cycles, with FEBDLYCLK low for the first CLKDIV cycles and high for the second CLKDIV cycles.
REQ-018 FEBDLYIN SHALL change only while FEBDLYCLK is low, at the start of each bit period.
REQ-019 After the last bit's high phase completes, the block SHALL enter LOAD. In LOAD: FEBDLYAE=0, FEBDLYCLK=0, FEBDLYIN=0, FEBLOADDLY=1 for exactly 2*CLKDIV cycles.
REQ-020 After LOAD, the block SHALL enter FINISH for one cycle with DONE=1 and BUSY=0, then return to IDLE.
REQ-021 BUSY=1 in SHIFT and LOAD only.
REQ-022 For START sampled at cycle 0, BUSY SHALL be high for cycles 1 through (NCHIP*DBITS+1)*2*CLKDIV, and DONE SHALL be high in the next cycle. With the defaults this is BUSY for cycles 1..144 and DONE at cycle 145.
REQ-023 The bit counter SHALL be sized as ceil(log2(NCHIP*DBITS+1)) and SHALL terminate exactly at NCHIP*DBITS with no wrap-around. The divider counter SHALL terminate at CLKDIV-1.
REQ-024 START asserted in the FINISH cycle SHALL be ignored. START asserted in the first IDLE cycle after FINISH SHALL begin a new sequence.
REQ-025 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-026 RST=1 at any clock edge, including mid-SHIFT or mid-LOAD, SHALL force IDLE and clear all counters and the shift register.
REQ-027 The same edge SHALL drive FEBDLYAE=0, FEBDLYCLK=0, FEBDLYIN=0, FEBLOADDLY=0, BUSY=0 and DONE=0.
REQ-028 START coincident with RST SHALL be ignored.
REQ-029 An aborted sequence SHALL NOT produce DONE or FEBLOADDLY.

Structure
REQ-030 A shared package SHALL hold the state encoding constants and the default NCHIP, DBITS and CLKDIV values. serfmem and this block SHALL use the same package.
REQ-031 No sub-module: a single FSM with a divider counter, a bit counter and a shift register.

Verification
REQ-032 DLY_VEC = {7{5'h1F}}, START pulse -> 35 FEBDLYCLK rising edges, FEBDLYIN=1 on every edge, FEBLOADDLY high for 4 cycles, DONE at cycle 145.
REQ-033 DLY_VEC = 35'h4_0000_0001 -> FEBDLYIN=1 on the first and last rising edges only; a bench-side chain model latches chip6=5'h10 and chip0=5'h01.
REQ-034 Second START at cycle 50 of an active sequence -> ignored; a single DONE at cycle 145.
REQ-035 RST for 1 cycle at cycle 70 -> all outputs 0 on the next edge, no FEBLOADDLY, no DONE. A fresh START afterwards completes normally in 145 cycles.
REQ-036 CLKDIV=1 build -> FEBDLYCLK period 2 cycles, BUSY for 72 cycles. Back-to-back START in the first IDLE cycle after FINISH is accepted.

Source files
------------

// File: rtl/feb_dly_prog_pkg.sv
// Shared constants and FSM encoding for the FEB clock-delay chain programmer.
package feb_dly_prog_pkg;

  localparam int unsigned NCHIP_DEF  = 7;
  localparam int unsigned DBITS_DEF  = 5;
  localparam int unsigned CLKDIV_DEF = 2;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StLoad,
    StFinish
  } feb_state_e;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/feb_dly_prog.sv
// Serially programs a chain of FEB clock-delay chips: shifts the captured codes MSB first,
// then pulses the load strobe. All outputs are registered.
module feb_dly_prog
  import feb_dly_prog_pkg::*;
#(
  parameter int unsigned NCHIP  = NCHIP_DEF,
  parameter int unsigned DBITS  = DBITS_DEF,
  parameter int unsigned CLKDIV = CLKDIV_DEF
) (
  input  logic                   CLKCMS,
  input  logic                   RST,
  input  logic                   START,
  input  logic [NCHIP*DBITS-1:0] DLY_VEC,
  output logic                   FEBDLYAE,
  output logic                   FEBDLYCLK,
  output logic                   FEBDLYIN,
  output logic                   FEBLOADDLY,
  output logic                   BUSY,
  output logic                   DONE
);

  localparam int unsigned NBits = NCHIP * DBITS;
  localparam int unsigned BitW  = cnt_width(NBits + 1);
  localparam int unsigned DivW  = cnt_width(CLKDIV);

  feb_state_e       state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic             phase_q, phase_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic [NBits-1:0] sreg_q, sreg_d;

  logic ae_q, ae_d;
  logic fclk_q, fclk_d;
  logic fin_q, fin_d;
  logic load_q, load_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic div_end;
  assign div_end = (div_q == DivW'(CLKDIV - 1));

  // phase_q selects the low (0) or high (1) half of each FEBDLYCLK period.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    sreg_d  = sreg_q;

    unique case (state_q)
      StIdle: begin
        if (START) begin
          sreg_d  = DLY_VEC;
          div_d   = '0;
          phase_d = 1'b0;
          bit_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (div_end) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            sreg_d  = {sreg_q[NBits-2:0], 1'b0};
            bit_d   = bit_q + 1'b1;
            if (bit_q == BitW'(NBits - 1)) begin
              state_d = StLoad;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StLoad: begin
        // Load strobe spans one full divided clock period.
        if (div_end) begin
          div_d   = '0;
          phase_d = ~phase_q;
          if (phase_q) begin
            state_d = StFinish;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are derived from next-state values so they register in step with the FSM.
  always_comb begin
    ae_d   = (state_d == StShift);
    fclk_d = ae_d & phase_d;
    fin_d  = ae_d & sreg_d[NBits-1];
    load_d = (state_d == StLoad);
    busy_d = ae_d | load_d;
    done_d = (state_d == StFinish);
  end

  always_ff @(posedge CLKCMS) begin
    if (RST) begin
      state_q <= StIdle;
      div_q   <= '0;
      phase_q <= 1'b0;
      bit_q   <= '0;
      sreg_q  <= '0;
      ae_q    <= 1'b0;
      fclk_q  <= 1'b0;
      fin_q   <= 1'b0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
      ae_q    <= ae_d;
      fclk_q  <= fclk_d;
      fin_q   <= fin_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign FEBDLYAE   = ae_q;
  assign FEBDLYCLK  = fclk_q;
  assign FEBDLYIN   = fin_q;
  assign FEBLOADDLY = load_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;

endmodule

// File: tb/tb_feb_dly_prog.sv
// Directed bench for feb_dly_prog: default build plus a CLKDIV=1 build, with a chain model
// that captures FEBDLYIN on each FEBDLYCLK rising edge.
module tb_feb_dly_prog;
  import feb_dly_prog_pkg::*;

  localparam int NB = 35;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, start_a, rst_b, start_b;
  logic [NB-1:0] vec_a, vec_b;
  logic a_ae, a_fclk, a_fin, a_load, a_busy, a_done;
  logic b_ae, b_fclk, b_fin, b_load, b_busy, b_done;

  feb_dly_prog u_dut_a (
    .CLKCMS    (clk),
    .RST       (rst_a),
    .START     (start_a),
    .DLY_VEC   (vec_a),
    .FEBDLYAE  (a_ae),
    .FEBDLYCLK (a_fclk),
    .FEBDLYIN  (a_fin),
    .FEBLOADDLY(a_load),
    .BUSY      (a_busy),
    .DONE      (a_done)
  );

  feb_dly_prog #(.CLKDIV(1)) u_dut_b (
    .CLKCMS    (clk),
    .RST       (rst_b),
    .START     (start_b),
    .DLY_VEC   (vec_b),
    .FEBDLYAE  (b_ae),
    .FEBDLYCLK (b_fclk),
    .FEBDLYIN  (b_fin),
    .FEBLOADDLY(b_load),
    .BUSY      (b_busy),
    .DONE      (b_done)
  );

  int errs = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Chain model and monitors, sampled on the falling edge.
  int            a_rises = 0, a_ones = 0, a_viol = 0, a_load_cyc = 0;
  logic [NB-1:0] a_chain = '0, a_latched = '0;
  logic          a_pclk = 1'b0, a_pin = 1'b0, a_pload = 1'b0;

  always @(negedge clk) begin
    if (a_fclk && !a_pclk) begin
      a_rises++;
      a_ones  += int'(a_fin);
      a_chain = {a_chain[NB-2:0], a_fin};
    end
    if (a_fclk && a_pclk && (a_fin != a_pin)) a_viol++;
    if (a_load) a_load_cyc++;
    if (a_load && !a_pload) a_latched = a_chain;
    a_pclk  = a_fclk;
    a_pin   = a_fin;
    a_pload = a_load;
  end

  int   b_cyc = 0, b_rises = 0, b_gap_bad = 0, b_seq_rise = 0, b_last = 0;
  logic b_pclk = 1'b0;

  always @(negedge clk) begin
    b_cyc++;
    if (!b_busy) b_seq_rise = 0;
    if (b_fclk && !b_pclk) begin
      if (b_seq_rise > 0 && (b_cyc - b_last) != 2) b_gap_bad++;
      b_seq_rise++;
      b_rises++;
      b_last = b_cyc;
    end
    b_pclk = b_fclk;
  end

  // Pulses START (sampled at edge 0), then runs ncyc cycles; cycle n shows edge n-1 results.
  task automatic run_a(input logic [NB-1:0] vec, input int start2_at, input int rst_at,
                       input int vec_chg_at, input int ncyc,
                       output int bfirst, output int blast, output int bcnt,
                       output int dcyc, output int dcnt, output logic [5:0] outs_rst);
    bfirst = 0; blast = 0; bcnt = 0; dcyc = 0; dcnt = 0; outs_rst = '1;
    vec_a = vec;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      if (a_busy) begin
        if (bfirst == 0) bfirst = cyc;
        blast = cyc;
        bcnt++;
      end
      if (a_done) begin
        if (dcyc == 0) dcyc = cyc;
        dcnt++;
      end
      if (cyc == rst_at + 1) outs_rst = {a_ae, a_fclk, a_fin, a_load, a_busy, a_done};
      start_a = (cyc == start2_at);
      rst_a   = (cyc == rst_at);
      if (cyc == vec_chg_at) vec_a = ~vec;
      @(posedge clk); #1;
    end
    start_a = 1'b0;
    rst_a   = 1'b0;
  endtask

  int            bf, bl, bc, dc, dn, r0, o0, l0, v0;
  logic [5:0]    orst;
  logic [NB-1:0] pat;

  initial begin
    rst_a = 1'b1; start_a = 1'b1; vec_a = '1;
    rst_b = 1'b1; start_b = 1'b1; vec_b = '1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_outs_a", {a_ae, a_fclk, a_fin, a_load, a_busy, a_done}, 6'b0);
    check_eq("reset_outs_b", {b_ae, b_fclk, b_fin, b_load, b_busy, b_done}, 6'b0);
    rst_a = 1'b0; start_a = 1'b0;
    rst_b = 1'b0; start_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("start_with_rst_ignored", a_busy, 1'b0);

    // All-ones codes.
    r0 = a_rises; o0 = a_ones; l0 = a_load_cyc; v0 = a_viol;
    run_a({7{5'h1F}}, -1, -1, -1, 150, bf, bl, bc, dc, dn, orst);
    check_eq("ones_busy_first", bf, 1);
    check_eq("ones_busy_last", bl, 144);
    check_eq("ones_busy_cnt", bc, 144);
    check_eq("ones_done_cyc", dc, 145);
    check_eq("ones_done_cnt", dn, 1);
    check_eq("ones_rises", a_rises - r0, 35);
    check_eq("ones_in_high", a_ones - o0, 35);
    check_eq("ones_load_cyc", a_load_cyc - l0, 4);
    check_eq("ones_latched", a_latched, {NB{1'b1}});
    check_eq("ones_in_stable", a_viol - v0, 0);

    // Single first/last bit; DLY_VEC flipped mid-sequence must not matter.
    pat = 35'h4_0000_0001;
    r0 = a_rises; o0 = a_ones; v0 = a_viol;
    run_a(pat, -1, -1, 10, 150, bf, bl, bc, dc, dn, orst);
    check_eq("edge_rises", a_rises - r0, 35);
    check_eq("edge_in_high", a_ones - o0, 2);
    check_eq("edge_chip6", a_latched[34:30], 5'h10);
    check_eq("edge_chip0", a_latched[4:0], 5'h01);
    check_eq("edge_latched", a_latched, pat);
    check_eq("edge_done_cyc", dc, 145);
    check_eq("edge_in_stable", a_viol - v0, 0);

    // Second START mid-sequence is ignored.
    run_a(35'h1_2345_6789, 50, -1, -1, 150, bf, bl, bc, dc, dn, orst);
    check_eq("restart_done_cyc", dc, 145);
    check_eq("restart_done_cnt", dn, 1);
    check_eq("restart_busy_cnt", bc, 144);
    check_eq("restart_latched", a_latched, 35'h1_2345_6789);

    // Reset mid-SHIFT aborts without load or done.
    l0 = a_load_cyc;
    run_a(35'h5_5555_5555, -1, 70, -1, 150, bf, bl, bc, dc, dn, orst);
    check_eq("abort_outs_zero", orst, 6'b0);
    check_eq("abort_busy_last", bl, 70);
    check_eq("abort_done_cnt", dn, 0);
    check_eq("abort_load_cyc", a_load_cyc - l0, 0);

    // Fresh sequence after abort completes normally.
    run_a(35'h2_AAAA_AAAA, -1, -1, -1, 150, bf, bl, bc, dc, dn, orst);
    check_eq("fresh_done_cyc", dc, 145);
    check_eq("fresh_busy_cnt", bc, 144);
    check_eq("fresh_latched", a_latched, 35'h2_AAAA_AAAA);

    // START during FINISH is ignored.
    run_a(35'h0_0F0F_0F0F, 145, -1, -1, 160, bf, bl, bc, dc, dn, orst);
    check_eq("finish_start_busy_cnt", bc, 144);
    check_eq("finish_start_done_cnt", dn, 1);

    // CLKDIV=1 build: 72 busy cycles, back-to-back START in the first IDLE cycle.
    r0 = b_rises;
    bc = 0; dn = 0; bf = 0; bl = 0;
    vec_b = 35'h3_1415_9265;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int cyc = 1; cyc <= 160; cyc++) begin
      if (b_busy) bc++;
      if (b_done) begin
        if (dn == 0) bf = cyc;
        else bl = cyc;
        dn++;
      end
      start_b = (cyc == 74);
      @(posedge clk); #1;
    end
    start_b = 1'b0;
    check_eq("div1_busy_cnt", bc, 144);
    check_eq("div1_done_cnt", dn, 2);
    check_eq("div1_done_first", bf, 73);
    check_eq("div1_done_second", bl, 147);
    check_eq("div1_rises", b_rises - r0, 70);
    check_eq("div1_clk_period", b_gap_bad, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
